maxnet_winner_detector: RTL and testbench

- Consumer end of the Maxnet activation stage.
- Each iteration it takes the N activated neuron outputs as a serial stream and counts the nonzero ones.
- It decides whether the competition is finished: one survivor, no survivors, or the iteration limit has been reached.
- It reports the winner index and value to the Maxnet controller through a valid/ready result handshake.

---
 rtl/maxnet_pkg.sv | 18 +
 rtl/fp32_is_zero.sv | 13 +
 rtl/maxnet_winner_detector.sv | 149 ++++++++++++++
 tb/tb_maxnet_winner_detector.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared Maxnet constants: default geometry, detector state encoding and the FP32 magnitude mask.
package maxnet_pkg;

   localparam int unsigned N_DEF        = 4;
   localparam int unsigned IDX_W_DEF    = 2;
   localparam int unsigned DATA_W_DEF   = 32;
   localparam int unsigned MAX_ITER_DEF = 64;
   localparam int unsigned ITER_W_DEF   = 7;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      REPORT  = 2'd2
   } state_e;

   localparam logic [31:0] FP32_ABS_MASK = 32'h7FFF_FFFF;

endpackage

// File: rtl/fp32_is_zero.sv
// Flags an IEEE-754 single-precision value as zero; +0 and -0 both qualify, denormals and NaN do not.
module fp32_is_zero
   import maxnet_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic [DATA_W-1:0] value,
   output logic              zero
);

   assign zero = ((value & DATA_W'(FP32_ABS_MASK)) == '0);

endmodule

// File: rtl/maxnet_winner_detector.sv
// Counts nonzero activations per Maxnet iteration and reports winner / no-survivor / timeout
// to the controller over a valid/ready result handshake.
module maxnet_winner_detector
   import maxnet_pkg::*;
#(
   parameter int unsigned N        = N_DEF,
   parameter int unsigned IDX_W    = IDX_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned MAX_ITER = MAX_ITER_DEF,
   parameter int unsigned ITER_W   = ITER_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic              res_done,
   output logic              res_winner,
   output logic              res_timeout,
   output logic [IDX_W-1:0]  res_idx,
   output logic [DATA_W-1:0] res_value,
   output logic [IDX_W:0]    res_count,
   output logic [ITER_W-1:0] res_iter,
   output logic              busy
);

   state_e              state_q;
   logic [IDX_W-1:0]    beat_q;
   logic [IDX_W:0]      count_q;
   logic [ITER_W-1:0]   iter_q;
   logic [IDX_W-1:0]    cap_idx_q;
   logic [DATA_W-1:0]   cap_val_q;

   logic                res_done_q;
   logic                res_winner_q;
   logic                res_timeout_q;
   logic [IDX_W-1:0]    res_idx_q;
   logic [DATA_W-1:0]   res_value_q;
   logic [IDX_W:0]      res_count_q;
   logic [ITER_W-1:0]   res_iter_q;

   logic                beat_zero;
   logic                beat_nz;
   logic                first_nz;
   logic                last_beat;
   logic                accept;
   logic [IDX_W:0]      count_nxt;
   logic [ITER_W-1:0]   iter_nxt;
   logic                iter_limit;

   fp32_is_zero #(
      .DATA_W (DATA_W)
   ) u_is_zero (
      .value (in_data),
      .zero  (beat_zero)
   );

   always_comb begin
      accept     = (state_q == COLLECT) && in_valid;
      beat_nz    = ~beat_zero;
      first_nz   = beat_nz && (count_q == '0);
      last_beat  = (beat_q == IDX_W'(N - 1));
      count_nxt  = count_q + (IDX_W + 1)'(beat_nz);
      iter_nxt   = iter_q + ITER_W'(1);
      iter_limit = (iter_nxt == ITER_W'(MAX_ITER));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         beat_q        <= '0;
         count_q       <= '0;
         iter_q        <= '0;
         cap_idx_q     <= '0;
         cap_val_q     <= '0;
         res_done_q    <= 1'b0;
         res_winner_q  <= 1'b0;
         res_timeout_q <= 1'b0;
         res_idx_q     <= '0;
         res_value_q   <= '0;
         res_count_q   <= '0;
         res_iter_q    <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= COLLECT;
                  beat_q    <= '0;
                  count_q   <= '0;
                  iter_q    <= '0;
                  cap_idx_q <= '0;
                  cap_val_q <= '0;
               end
            end
            COLLECT: begin
               if (accept) begin
                  beat_q  <= beat_q + IDX_W'(1);
                  count_q <= count_nxt;
                  if (first_nz) begin
                     cap_idx_q <= beat_q;
                     cap_val_q <= in_data;
                  end
                  // Result fields are frozen here so they stay stable through REPORT.
                  if (last_beat) begin
                     state_q       <= REPORT;
                     iter_q        <= iter_nxt;
                     res_done_q    <= (count_nxt <= (IDX_W + 1)'(1)) || iter_limit;
                     res_winner_q  <= (count_nxt == (IDX_W + 1)'(1));
                     res_timeout_q <= (count_nxt > (IDX_W + 1)'(1)) && iter_limit;
                     res_idx_q     <= first_nz ? beat_q  : cap_idx_q;
                     res_value_q   <= first_nz ? in_data : cap_val_q;
                     res_count_q   <= count_nxt;
                     res_iter_q    <= iter_nxt;
                  end
               end
            end
            REPORT: begin
               if (res_ready) begin
                  if (res_done_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q   <= COLLECT;
                     beat_q    <= '0;
                     count_q   <= '0;
                     cap_idx_q <= '0;
                     cap_val_q <= '0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready    = (state_q == COLLECT);
   assign res_valid   = (state_q == REPORT);
   assign busy        = (state_q != IDLE);
   assign res_done    = res_done_q;
   assign res_winner  = res_winner_q;
   assign res_timeout = res_timeout_q;
   assign res_idx     = res_idx_q;
   assign res_value   = res_value_q;
   assign res_count   = res_count_q;
   assign res_iter    = res_iter_q;

endmodule

// File: tb/tb_maxnet_winner_detector.sv
// Bench for maxnet_winner_detector: directed scenarios plus randomized iterations, checked every
// cycle against a queue-based behavioural model.
module tb_maxnet_winner_detector;

   localparam int unsigned N        = 4;
   localparam int unsigned IDX_W    = 2;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned MAX_ITER = 3;
   localparam int unsigned ITER_W   = 7;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic              res_ready = 1'b0;
   logic              in_ready;
   logic              res_valid;
   logic              res_done;
   logic              res_winner;
   logic              res_timeout;
   logic [IDX_W-1:0]  res_idx;
   logic [DATA_W-1:0] res_value;
   logic [IDX_W:0]    res_count;
   logic [ITER_W-1:0] res_iter;
   logic              busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   maxnet_winner_detector #(
      .N        (N),
      .IDX_W    (IDX_W),
      .DATA_W   (DATA_W),
      .MAX_ITER (MAX_ITER),
      .ITER_W   (ITER_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_done    (res_done),
      .res_winner  (res_winner),
      .res_timeout (res_timeout),
      .res_idx     (res_idx),
      .res_value   (res_value),
      .res_count   (res_count),
      .res_iter    (res_iter),
      .busy        (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: mode 0 idle, 1 gathering beats, 2 holding a result.
   int          m_mode = 0;
   logic [31:0] m_beats[$];
   int          m_iter = 0;
   int          m_count = 0;
   int          m_idx = 0;
   logic [31:0] m_value = '0;
   bit          m_done = 0;
   bit          m_winner = 0;
   bit          m_timeout = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0;
         m_beats.delete();
         m_iter = 0;
      end else begin
         case (m_mode)
            0: if (start) begin
               m_mode = 1;
               m_beats.delete();
               m_iter = 0;
            end
            1: if (in_valid) begin
               m_beats.push_back(in_data);
               if (m_beats.size() == N) begin
                  m_iter++;
                  m_count = 0;
                  m_idx = 0;
                  m_value = '0;
                  for (int i = 0; i < N; i++) begin
                     if (m_beats[i][30:0] != 31'd0) begin
                        if (m_count == 0) begin
                           m_idx = i;
                           m_value = m_beats[i];
                        end
                        m_count++;
                     end
                  end
                  m_done    = (m_count <= 1) || (m_iter == MAX_ITER);
                  m_winner  = (m_count == 1);
                  m_timeout = (m_count > 1) && (m_iter == MAX_ITER);
                  m_mode = 2;
               end
            end
            default: if (res_ready) begin
               m_beats.delete();
               m_mode = m_done ? 0 : 1;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      chk("in_ready", 32'(in_ready), 32'(m_mode == 1));
      chk("res_valid", 32'(res_valid), 32'(m_mode == 2));
      chk("busy", 32'(busy), 32'(m_mode != 0));
      if (m_mode == 2) begin
         chk("res_done", 32'(res_done), 32'(m_done));
         chk("res_winner", 32'(res_winner), 32'(m_winner));
         chk("res_timeout", 32'(res_timeout), 32'(m_timeout));
         chk("res_idx", 32'(res_idx), 32'(m_idx));
         chk("res_value", res_value, m_value);
         chk("res_count", 32'(res_count), 32'(m_count));
         chk("res_iter", 32'(res_iter), 32'(m_iter));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Sends nb beats of v; start_at marks a beat during which start is (uselessly) pulsed.
   task automatic send_beats(input logic [31:0] v[4], input bit gaps, input int start_at,
                             input int nb);
      for (int k = 0; k < 40 && !in_ready; k++) tick();
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      for (int b = 0; b < nb; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               in_valid = 1'b0;
               in_data = $urandom;
               tick();
            end
         end
         start = (b == start_at);
         in_valid = 1'b1;
         in_data = v[b];
         tick();
      end
      start = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic check_res(input string tag, input bit done, input bit win, input bit tmo,
                            input int idx, input logic [31:0] val, input int cnt, input int it);
      chk({tag, "_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_done"}, 32'(res_done), 32'(done));
      chk({tag, "_winner"}, 32'(res_winner), 32'(win));
      chk({tag, "_timeout"}, 32'(res_timeout), 32'(tmo));
      chk({tag, "_idx"}, 32'(res_idx), 32'(idx));
      chk({tag, "_value"}, res_value, val);
      chk({tag, "_count"}, 32'(res_count), 32'(cnt));
      chk({tag, "_iter"}, 32'(res_iter), 32'(it));
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(res_done), 32'd0);
      chk({tag, "_winner"}, 32'(res_winner), 32'd0);
      chk({tag, "_timeout"}, 32'(res_timeout), 32'd0);
      chk({tag, "_idx"}, 32'(res_idx), 32'd0);
      chk({tag, "_value"}, res_value, 32'd0);
      chk({tag, "_count"}, 32'(res_count), 32'd0);
      chk({tag, "_iter"}, 32'(res_iter), 32'd0);
   endtask

   function automatic logic [31:0] rand_val();
      case ($urandom_range(0, 5))
         0, 1:    return 32'h0000_0000;
         2:       return 32'h8000_0000;
         3:       return $urandom & 32'h807F_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] v[4];
      bit          hs;

      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Single survivor; -0 on the last beat must not count.
      res_ready = 1'b1;
      pulse_start();
      v = '{32'h0, 32'h3F00_0000, 32'h0, 32'h8000_0000};
      send_beats(v, 1'b0, -1, 4);
      check_res("single", 1, 1, 0, 1, 32'h3F00_0000, 1, 1);
      tick();
      chk("single_idle", 32'(busy), 32'd0);

      // No survivors.
      pulse_start();
      v = '{32'h0, 32'h0, 32'h0, 32'h0};
      send_beats(v, 1'b0, -1, 4);
      check_res("allzero", 1, 0, 0, 0, 32'h0, 0, 1);
      tick();

      // Two iterations with backpressure, stray in_valid and a start pulse mid-collect.
      res_ready = 1'b0;
      pulse_start();
      v = '{32'h3F80_0000, 32'h3F00_0000, 32'h0, 32'h0};
      send_beats(v, 1'b1, -1, 4);
      check_res("multi1", 0, 0, 0, 0, 32'h3F80_0000, 2, 1);
      repeat (5) begin
         in_valid = 1'b1;
         in_data = $urandom;
         tick();
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_valid", 32'(res_valid), 32'd1);
         chk("bp_count", 32'(res_count), 32'd2);
         chk("bp_value", res_value, 32'h3F80_0000);
      end
      in_valid = 1'b0;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      v = '{32'h3E80_0000, 32'h0, 32'h0, 32'h0};
      send_beats(v, 1'b1, 1, 4);
      check_res("multi2", 1, 1, 0, 0, 32'h3E80_0000, 1, 2);
      res_ready = 1'b1;
      tick();

      // Iteration limit with two survivors every time.
      pulse_start();
      for (int it = 1; it <= 3; it++) begin
         v = '{32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h0};
         send_beats(v, 1'b0, -1, 4);
         check_res("timeout", it == 3, 0, it == 3, 1, 32'h3F80_0000, 2, it);
      end
      tick();
      chk("timeout_idle", 32'(busy), 32'd0);

      // Asynchronous reset partway through the second iteration.
      pulse_start();
      v = '{32'h3F80_0000, 32'h3F80_0000, 32'h0, 32'h0};
      send_beats(v, 1'b0, -1, 4);
      tick();
      send_beats(v, 1'b0, -1, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      tick();
      rst_n = 1'b1;
      tick();
      pulse_start();
      v = '{32'h0, 32'h0, 32'h4040_0000, 32'h0};
      send_beats(v, 1'b0, -1, 4);
      check_res("fresh", 1, 1, 0, 2, 32'h4040_0000, 1, 1);
      tick();

      // Randomized iterations; the per-cycle model comparison does the checking.
      res_ready = 1'b0;
      for (int t = 0; t < 80; t++) begin
         if (!busy) pulse_start();
         for (int b = 0; b < 4; b++) v[b] = rand_val();
         send_beats(v, 1'b1, $urandom_range(0, 7), 4);
         hs = 1'b0;
         for (int k = 0; k < 40; k++) begin
            res_ready = $urandom_range(0, 1);
            in_valid = $urandom_range(0, 1);
            in_data = $urandom;
            tick();
            if (!res_valid) begin
               hs = 1'b1;
               break;
            end
         end
         res_ready = 1'b0;
         in_valid = 1'b0;
         chk("handshake_bound", 32'(hs), 32'd1);
      end

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
